// File: rtl/sb_routed_v2_if.sv
// sb_routed_v2_if: config chain and track bundle for the double-buffered switch box
interface sb_routed_v2_if #(parameter int WIDTH = 32);
    logic             en;
    logic             config_en;
    logic             config_data_in;
    logic             config_commit;
    logic             config_data_out;
    logic             cfg_dirty;
    logic [WIDTH-1:0] north_in, east_in, south_in, west_in;
    logic [WIDTH-1:0] north_out, east_out, south_out, west_out;
    modport master (
        output en, config_en, config_data_in, config_commit,
        output north_in, east_in, south_in, west_in,
        input  config_data_out, cfg_dirty,
        input  north_out, east_out, south_out, west_out
    );
    modport slave (
        input  en, config_en, config_data_in, config_commit,
        input  north_in, east_in, south_in, west_in,
        output config_data_out, cfg_dirty,
        output north_out, east_out, south_out, west_out
    );
endinterface

// File: rtl/sb_routed_v2.sv
// sb_routed_v2: per-track switch box with shadow/active double-buffered config and optional output register
module sb_routed_v2 #(
    parameter int WIDTH   = 32,
    parameter int REG_OUT = 0
) (
    input logic          clk,
    input logic          rst,
    sb_routed_v2_if.slave bus
);
    localparam int CFG_BITS = 8 * WIDTH;
    logic [CFG_BITS-1:0]    r_shadow;
    logic [CFG_BITS-1:0]    r_active;
    logic                   r_dirty;
    logic [3:0][WIDTH-1:0]  w_in;
    logic [3:0][WIDTH-1:0]  w_out;
    // commit captures the pre-shift shadow; a concurrent shift keeps the box dirty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_dirty  <= 1'b0;
        end else if (bus.en) begin
            if (bus.config_en) r_shadow <= {r_shadow[CFG_BITS-2:0], bus.config_data_in};
            if (bus.config_commit) r_active <= r_shadow;
            r_dirty <= bus.config_en ? 1'b1 : bus.config_commit ? 1'b0 : r_dirty;
        end
    end
    assign w_in = {bus.west_in, bus.south_in, bus.east_in, bus.north_in};
    // source side is (d + sel) mod 4, so sel 00 means off and loopback cannot occur
    for (genvar d = 0; d < 4; d++) begin : g_side
        for (genvar t = 0; t < WIDTH; t++) begin : g_trk
            logic [1:0] w_sel;
            logic [1:0] w_src;
            assign w_sel       = r_active[(d*WIDTH+t)*2 +: 2];
            assign w_src       = w_sel + 2'(d);
            assign w_out[d][t] = (w_sel != 2'b00) && w_in[w_src][t];
        end
    end
    if (REG_OUT != 0) begin : g_reg
        logic [3:0][WIDTH-1:0] r_out;
        always_ff @(posedge clk) begin
            if (rst) r_out <= '0;
            else     r_out <= w_out;
        end
        assign {bus.west_out, bus.south_out, bus.east_out, bus.north_out} = r_out;
    end else begin : g_comb
        assign {bus.west_out, bus.south_out, bus.east_out, bus.north_out} = w_out;
    end
    assign bus.config_data_out = r_shadow[CFG_BITS-1];
    assign bus.cfg_dirty       = r_dirty;
endmodule

// File: tb/tb_sb_routed_v2.sv
// tb_sb_routed_v2: directed vectors for the WIDTH=4 switch box, combinational and registered variants
module tb_sb_routed_v2;
    logic clk = 1'b0;
    logic rst, en, cen, din, cmt;
    logic [3:0] nin, ein, sin, win;
    int total = 0;
    int passed = 0;
    sb_routed_v2_if #(.WIDTH(4)) if0 ();
    sb_routed_v2_if #(.WIDTH(4)) if1 ();
    sb_routed_v2 #(.WIDTH(4), .REG_OUT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sb_routed_v2 #(.WIDTH(4), .REG_OUT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    assign if0.en = en;             assign if1.en = en;
    assign if0.config_en = cen;     assign if1.config_en = cen;
    assign if0.config_data_in = din; assign if1.config_data_in = din;
    assign if0.config_commit = cmt; assign if1.config_commit = cmt;
    assign if0.north_in = nin;      assign if1.north_in = nin;
    assign if0.east_in = ein;       assign if1.east_in = ein;
    assign if0.south_in = sin;      assign if1.south_in = sin;
    assign if0.west_in = win;       assign if1.west_in = win;
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        logic [31:0] cfg;
        logic [15:0] in_nesw;
        logic [15:0] exp_nesw;
    } vec_t;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic shift_word(input logic [31:0] wd);
        en  = 1'b1;
        cen = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            din = wd[i];
            step();
        end
        cen = 1'b0;
        din = 1'b0;
    endtask
    task automatic commit();
        en  = 1'b1;
        cmt = 1'b1;
        step();
        cmt = 1'b0;
    endtask
    task automatic set_in(input logic [15:0] v);
        {nin, ein, sin, win} = v;
    endtask
    function automatic logic [15:0] outs0();
        return {if0.north_out, if0.east_out, if0.south_out, if0.west_out};
    endfunction
    function automatic logic [15:0] outs1();
        return {if1.north_out, if1.east_out, if1.south_out, if1.west_out};
    endfunction
    vec_t vt[8];
    logic [3:0] vals[5];
    logic bits[40];
    logic [3:0] prev;
    initial begin
        vt[0] = '{"off",        32'h0000_0000, 16'hFFFF, 16'h0000};
        vt[1] = '{"n0_from_w",  32'h0000_0003, 16'h0001, 16'h1000};
        vt[2] = '{"all_01",     32'h5555_5555, 16'h1248, 16'h2481};
        vt[3] = '{"all_10",     32'hAAAA_AAAA, 16'h1248, 16'h4812};
        vt[4] = '{"all_11",     32'hFFFF_FFFF, 16'h1248, 16'h8124};
        vt[5] = '{"mixed_hit",  32'h0000_00E4, 16'hF248, 16'hE000};
        vt[6] = '{"mixed_miss", 32'h0000_00E4, 16'hFD37, 16'h0000};
        vt[7] = '{"fanout",     32'h0020_3000, 16'h4000, 16'h0440};
        vals = '{4'h4, 4'h0, 4'h4, 4'hF, 4'h0};
        // reset with every input high
        rst = 1'b1; en = 1'b1; cen = 1'b1; din = 1'b1; cmt = 1'b1;
        set_in(16'hFFFF);
        step(); step();
        @(negedge clk);
        chk("rst_out0", 32'(outs0()), 32'h0);
        chk("rst_out1", 32'(outs1()), 32'h0);
        chk("rst_cdo", 32'(if0.config_data_out), 32'h0);
        chk("rst_dirty", 32'(if0.cfg_dirty), 32'h0);
        step();
        rst = 1'b0; cen = 1'b0; din = 1'b0; cmt = 1'b0;
        set_in(16'h0);
        for (int k = 0; k < 8; k++) begin
            shift_word(vt[k].cfg);
            commit();
            set_in(vt[k].in_nesw);
            @(negedge clk);
            chk({vt[k].name, "_comb"}, 32'(outs0()), 32'(vt[k].exp_nesw));
            chk({vt[k].name, "_dirty"}, 32'(if0.cfg_dirty), 32'h0);
            step();
            @(negedge clk);
            chk({vt[k].name, "_reg"}, 32'(outs1()), 32'(vt[k].exp_nesw));
        end
        // shadow load must not disturb the live route
        shift_word(32'h0000_0003);
        commit();
        set_in(16'h0001);
        en = 1'b1; cen = 1'b1; din = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            @(negedge clk);
            chk("shadow_live_n", 32'(if0.north_out), 32'h1);
            chk("shadow_dirty", 32'(if0.cfg_dirty), 32'h1);
        end
        step();
        cen = 1'b0;
        commit();
        @(negedge clk);
        chk("shadow_commit_n", 32'(if0.north_out), 32'h0);
        chk("shadow_commit_dirty", 32'(if0.cfg_dirty), 32'h0);
        // fan-out through the registered variant: one cycle of lag on both branches
        shift_word(32'h0020_3000);
        commit();
        set_in(16'h0);
        step(); step();
        prev = 4'h0;
        for (int k = 0; k < 5; k++) begin
            nin = vals[k];
            @(negedge clk);
            chk("fan_e_comb", 32'(if0.east_out), 32'(vals[k] & 4'h4));
            chk("fan_s_comb", 32'(if0.south_out), 32'(vals[k] & 4'h4));
            chk("fan_e_reg", 32'(if1.east_out), 32'(prev & 4'h4));
            chk("fan_s_reg", 32'(if1.south_out), 32'(prev & 4'h4));
            step();
            prev = vals[k];
        end
        @(negedge clk);
        chk("fan_e_reg_last", 32'(if1.east_out), 32'(prev & 4'h4));
        // simultaneous commit and shift
        shift_word(32'h5555_5555);
        cen = 1'b1; cmt = 1'b1; din = 1'b1;
        step();
        cen = 1'b0; cmt = 1'b0; din = 1'b0;
        set_in(16'h1248);
        @(negedge clk);
        chk("simul_out", 32'(outs0()), 32'h2481);
        chk("simul_dirty", 32'(if0.cfg_dirty), 32'h1);
        chk("simul_cdo", 32'(if0.config_data_out), 32'h1);
        en = 1'b0; cen = 1'b1; cmt = 1'b1;
        step();
        cen = 1'b0; cmt = 1'b0;
        @(negedge clk);
        chk("hold_out", 32'(outs0()), 32'h2481);
        chk("hold_dirty", 32'(if0.cfg_dirty), 32'h1);
        chk("hold_cdo", 32'(if0.config_data_out), 32'h1);
        commit();
        @(negedge clk);
        chk("shifted_commit_out", 32'(outs0()), 32'h4812 & 16'hEFFF);
        chk("shifted_commit_dirty", 32'(if0.cfg_dirty), 32'h0);
        // reset in the middle of a shift with commit asserted
        set_in(16'hFFFF);
        en = 1'b1; cen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1; cmt = 1'b1;
        step();
        rst = 1'b0; cen = 1'b0; cmt = 1'b0; din = 1'b0;
        @(negedge clk);
        chk("midrst_out0", 32'(outs0()), 32'h0);
        chk("midrst_out1", 32'(outs1()), 32'h0);
        chk("midrst_cdo", 32'(if0.config_data_out), 32'h0);
        chk("midrst_dirty", 32'(if0.cfg_dirty), 32'h0);
        // chain: output reproduces input 32 enabled shifts later
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        bits[0] = 1'b1;
        cen = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = bits[i];
            step();
            @(negedge clk);
            chk("chain_cdo", 32'(if0.config_data_out), (i >= 31) ? 32'(bits[i-31]) : 32'h0);
        end
        cen = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
